mem_access_stage: RTL and testbench

Parametrised memory-access stage with MEM/WB pipeline register. Sits between EX and WB: accepts one instruction per handshake, forwards the WB result into store data, performs word/half/byte loads and stores with sign/zero extension, and registers the write-back bundle. Unlike the fixed single-cycle stage it replaces, it supports configurable memory depth and multi-cycle memory latency with back-pressure to EX, and flags misaligned accesses.

---
 rtl/mem_stage_pkg.sv | 44 ++++
 rtl/mem_access_stage_dm_array.sv | 35 +++
 rtl/mem_access_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared op codes, FSM encoding and op-classification helpers for the
// memory-access stage and its RAM.
package mem_stage_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_SH   = 4'd10;
    localparam logic [3:0] OP_SB   = 4'd11;

    localparam int DEF_MEM_LAT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    // Word ops need a 4-byte aligned address, half ops a 2-byte aligned one.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic w_word;
        logic w_half;
        w_word = (op == OP_LW) || (op == OP_SW);
        w_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        return (w_word && (lane != 2'b00)) || (w_half && lane[0]);
    endfunction

endpackage

// File: rtl/mem_access_stage_dm_array.sv
// Word-organised data RAM: synchronous byte-enabled write, combinational
// read, whole array cleared on reset.
module dm_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-3:0] i_widx,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_widx];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage with MEM/WB register: one instruction in flight, memory ops take
// MEM_LAT cycles (back-pressure via in_ready), other ops retire in one cycle.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_rd2,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_a3,
    input  logic        in_rfwr,
    output logic        out_valid,
    output logic        out_rfwr,
    output logic [4:0]  out_a3,
    output logic [31:0] out_wd,
    output logic [31:0] out_pc,
    output logic        out_misalign
);

    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [3:0]  r_op;
    logic [31:0] r_alu;
    logic [31:0] r_pc;
    logic [31:0] r_sd;
    logic [4:0]  r_a3;
    logic        r_rfwr;

    logic        r_out_valid;
    logic        r_out_rfwr;
    logic [4:0]  r_out_a3;
    logic [31:0] r_out_wd;
    logic [31:0] r_out_pc;
    logic        r_out_misalign;

    logic        w_idle;
    logic        w_accept;
    logic        w_complete;
    logic        w_fwd;
    logic [31:0] w_sd_in;
    logic [3:0]  w_op;
    logic [31:0] w_alu;
    logic [31:0] w_pc;
    logic [31:0] w_sd;
    logic [4:0]  w_a3;
    logic        w_rfwr;
    logic        w_mis;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [31:0] w_wd;

    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [31:0] word,
                                                input logic [1:0] lane);
        logic [7:0]  w_b;
        logic [15:0] w_h;
        w_b = word[{lane, 3'b000} +: 8];
        w_h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   return {{24{w_b[7]}}, w_b};
            OP_LBU:  return {24'd0, w_b};
            OP_LH:   return {{16{w_h[15]}}, w_h};
            OP_LHU:  return {16'd0, w_h};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            OP_SH:   return lane[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] sd);
        case (op)
            OP_SH:   return {2{sd[15:0]}};
            OP_SB:   return {4{sd[7:0]}};
            default: return sd;
        endcase
    endfunction

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && in_valid;
    assign in_ready = w_idle;

    // Forward from the instruction currently sitting in the output register.
    assign w_fwd   = r_out_valid && r_out_rfwr && (r_out_a3 != 5'd0) && (r_out_a3 == in_rt);
    assign w_sd_in = w_fwd ? r_out_wd : in_rd2;

    // From IDLE an op completes on its accept edge, so it uses the live inputs.
    assign w_op   = w_idle ? in_op   : r_op;
    assign w_alu  = w_idle ? in_alu  : r_alu;
    assign w_pc   = w_idle ? in_pc   : r_pc;
    assign w_sd   = w_idle ? w_sd_in : r_sd;
    assign w_a3   = w_idle ? in_a3   : r_a3;
    assign w_rfwr = w_idle ? in_rfwr : r_rfwr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (op_is_mem(in_op) && (MEM_LAT > 1)) begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
                    end else begin
                        w_complete = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_complete  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_mis   = op_misaligned(w_op, w_alu[1:0]);
        w_we    = w_complete && op_is_store(w_op) && !w_mis;
        w_be    = store_be(w_op, w_alu[1:0]);
        w_wdata = store_lanes(w_op, w_sd);
        w_wd    = w_alu;
        if (w_mis) begin
            w_wd = '0;
        end else if (op_is_load(w_op)) begin
            w_wd = load_extend(w_op, w_rdata, w_alu[1:0]);
        end
    end

    dm_array #(
        .ADDR_W(ADDR_W)
    ) u_dm (
        .clk    (clk),
        .reset  (reset),
        .i_we   (w_we),
        .i_be   (w_be),
        .i_widx (w_alu[ADDR_W-1:2]),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Accept boundary: hold the instruction for multi-cycle memory ops.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= in_op;
            r_alu  <= in_alu;
            r_pc   <= in_pc;
            r_sd   <= w_sd_in;
            r_a3   <= in_a3;
            r_rfwr <= in_rfwr;
        end
    end

    // MEM/WB boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_rfwr     <= 1'b0;
            r_out_misalign <= 1'b0;
            r_out_a3       <= '0;
            r_out_wd       <= '0;
            r_out_pc       <= '0;
        end else begin
            r_out_valid    <= w_complete;
            r_out_rfwr     <= w_complete && w_rfwr && !w_mis;
            r_out_misalign <= w_complete && w_mis;
            if (w_complete) begin
                r_out_a3 <= w_a3;
                r_out_wd <= w_wd;
                r_out_pc <= w_pc;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_rfwr     = r_out_rfwr;
    assign out_a3       = r_out_a3;
    assign out_wd       = r_out_wd;
    assign out_pc       = r_out_pc;
    assign out_misalign = r_out_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, selected by sel; table vectors, timing sequences, random vs model.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        d_valid;
    logic [3:0]  d_op;
    logic [31:0] d_pc, d_alu, d_rd2;
    logic [4:0]  d_rt, d_a3;
    logic        d_rfwr;

    logic        v1, v3;
    logic        rdy1, val1, rfwr1, mis1, rdy3, val3, rfwr3, mis3;
    logic [4:0]  a31, a33;
    logic [31:0] wd1, pc1, wd3, pc3;

    assign v1 = d_valid & ~sel;
    assign v3 = d_valid & sel;

    mem_access_stage #(.ADDR_W(12), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1), .in_pc(d_pc),
        .in_op(d_op), .in_alu(d_alu), .in_rd2(d_rd2), .in_rt(d_rt), .in_a3(d_a3),
        .in_rfwr(d_rfwr), .out_valid(val1), .out_rfwr(rfwr1), .out_a3(a31),
        .out_wd(wd1), .out_pc(pc1), .out_misalign(mis1));

    mem_access_stage #(.ADDR_W(12), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset), .in_valid(v3), .in_ready(rdy3), .in_pc(d_pc),
        .in_op(d_op), .in_alu(d_alu), .in_rd2(d_rd2), .in_rt(d_rt), .in_a3(d_a3),
        .in_rfwr(d_rfwr), .out_valid(val3), .out_rfwr(rfwr3), .out_a3(a33),
        .out_wd(wd3), .out_pc(pc3), .out_misalign(mis3));

    logic        o_ready, o_valid, o_rfwr, o_mis;
    logic [4:0]  o_a3;
    logic [31:0] o_wd, o_pc;
    assign o_ready = sel ? rdy3  : rdy1;
    assign o_valid = sel ? val3  : val1;
    assign o_rfwr  = sel ? rfwr3 : rfwr1;
    assign o_mis   = sel ? mis3  : mis1;
    assign o_a3    = sel ? a33   : a31;
    assign o_wd    = sel ? wd3   : wd1;
    assign o_pc    = sel ? pc3   : pc1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, want);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [4:0] rt, input logic [4:0] a3, input logic rf,
                         input logic [31:0] pc);
        d_op = op; d_alu = alu; d_rd2 = rd2; d_rt = rt; d_a3 = a3; d_rfwr = rf; d_pc = pc;
        d_valid = 1'b1;
    endtask

    task automatic accept_wait();
        int n = 0;
        while (o_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_bound", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
        d_valid = 1'b0;
    endtask

    task automatic wait_retire();
        int n = 0;
        while (o_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("retire_bound", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  rt;
        logic [4:0]  a3;
        logic        rfwr;
        logic [31:0] wd;
        logic        wrf;
        logic        mis;
    } vec_t;
    vec_t tv [26];

    // Behavioural model: byte-addressed memory plus expected output registers.
    logic [7:0]  m_mem [4096];
    logic        e_valid, e_rfwr, e_mis, p_mis, p_rfwr, pend;
    logic [4:0]  e_a3, p_a3;
    logic [31:0] e_wd, e_pc, p_wd, p_pc;
    int          cyc, ready_at, retire_at;

    task automatic model_accept(input int lat);
        int          a, size;
        logic        ld, st, mis;
        logic [31:0] sd, v;
        a  = int'(d_alu % 32'd4096);
        ld = d_op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
        st = d_op inside {OP_SW, OP_SH, OP_SB};
        case (d_op)
            OP_LW, OP_SW:         size = 4;
            OP_LH, OP_LHU, OP_SH: size = 2;
            OP_LB, OP_LBU, OP_SB: size = 1;
            default:              size = 0;
        endcase
        mis = (size > 1) && ((a % size) != 0);
        sd  = (e_valid && e_rfwr && e_a3 != 5'd0 && e_a3 == d_rt) ? e_wd : d_rd2;
        p_a3 = d_a3; p_pc = d_pc; p_mis = mis; p_rfwr = d_rfwr && !mis;
        if (mis) begin
            p_wd = 32'd0;
        end else if (st) begin
            for (int b = 0; b < size; b++) m_mem[a + b] = 8'(sd >> (8 * b));
            p_wd = d_alu;
        end else if (ld) begin
            v = 32'd0;
            for (int b = 0; b < size; b++) v = v | (32'(m_mem[a + b]) << (8 * b));
            if (d_op == OP_LB) v = 32'($signed(v[7:0]));
            if (d_op == OP_LH) v = 32'($signed(v[15:0]));
            p_wd = v;
        end else begin
            p_wd = d_alu;
        end
        pend      = 1'b1;
        retire_at = cyc + ((ld || st) ? lat : 1);
        ready_at  = retire_at;
    endtask

    task automatic run_random(input int lat, input int ncyc);
        int r;
        reset = 1'b1; d_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4096; i++) m_mem[i] = 8'd0;
        e_valid = 0; e_rfwr = 0; e_mis = 0; e_a3 = 0; e_wd = 0; e_pc = 0; pend = 0;
        cyc = 0; ready_at = 0; retire_at = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (pend && retire_at == cyc) begin
                e_valid = 1; e_rfwr = p_rfwr; e_mis = p_mis; e_a3 = p_a3; e_wd = p_wd; e_pc = p_pc;
                pend = 0;
            end else begin
                e_valid = 0; e_rfwr = 0; e_mis = 0;
            end
            chk("rnd_ready", {31'd0, o_ready}, (cyc >= ready_at) ? 32'd1 : 32'd0);
            chk("rnd_valid", {31'd0, o_valid}, {31'd0, e_valid});
            chk("rnd_rfwr",  {31'd0, o_rfwr},  {31'd0, e_rfwr});
            chk("rnd_mis",   {31'd0, o_mis},   {31'd0, e_mis});
            chk("rnd_a3",    {27'd0, o_a3},    {27'd0, e_a3});
            chk("rnd_wd",    o_wd, e_wd);
            chk("rnd_pc",    o_pc, e_pc);
            case ($urandom_range(0, 9))
                0: d_op = OP_NONE;  1: d_op = OP_LW;  2: d_op = OP_LH;  3: d_op = OP_LHU;
                4: d_op = OP_LB;    5: d_op = OP_LBU; 6: d_op = OP_SW;  7: d_op = OP_SH;
                8: d_op = OP_SB;    default: d_op = 4'd6;
            endcase
            r = $urandom;
            d_alu   = (32'(r) & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            d_rd2   = $urandom;
            d_pc    = $urandom;
            d_rt    = 5'($urandom_range(0, 3));
            d_a3    = 5'($urandom_range(0, 3));
            d_rfwr  = 1'($urandom_range(0, 1));
            d_valid = ($urandom_range(0, 3) != 0);
            if (d_valid && cyc >= ready_at) model_accept(lat);
            @(posedge clk); #1;
            cyc++;
        end
        d_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sel = 1'b0; d_valid = 1'b0;
        d_op = OP_NONE; d_pc = 0; d_alu = 0; d_rd2 = 0; d_rt = 0; d_a3 = 0; d_rfwr = 0;

        tv[0]  = '{OP_SW,  32'h10,       32'h12345678, 5'd1, 5'd0,  1'b0, 32'h10,       1'b0, 1'b0};
        tv[1]  = '{OP_LW,  32'h10,       32'h0,        5'd0, 5'd8,  1'b1, 32'h12345678, 1'b1, 1'b0};
        tv[2]  = '{OP_SB,  32'h21,       32'h80,       5'd2, 5'd0,  1'b0, 32'h21,       1'b0, 1'b0};
        tv[3]  = '{OP_LB,  32'h21,       32'h0,        5'd0, 5'd3,  1'b1, 32'hFFFFFF80, 1'b1, 1'b0};
        tv[4]  = '{OP_LBU, 32'h21,       32'h0,        5'd0, 5'd4,  1'b1, 32'h00000080, 1'b1, 1'b0};
        tv[5]  = '{OP_LH,  32'h20,       32'h0,        5'd0, 5'd5,  1'b1, 32'hFFFF8000, 1'b1, 1'b0};
        tv[6]  = '{OP_SH,  32'h22,       32'h1234BEEF, 5'd1, 5'd0,  1'b0, 32'h22,       1'b0, 1'b0};
        tv[7]  = '{OP_LW,  32'h20,       32'h0,        5'd0, 5'd6,  1'b1, 32'hBEEF8000, 1'b1, 1'b0};
        tv[8]  = '{OP_LHU, 32'h22,       32'h0,        5'd0, 5'd7,  1'b1, 32'h0000BEEF, 1'b1, 1'b0};
        tv[9]  = '{OP_LH,  32'h22,       32'h0,        5'd0, 5'd7,  1'b1, 32'hFFFFBEEF, 1'b1, 1'b0};
        tv[10] = '{OP_SW,  32'h13,       32'hDEADBEEF, 5'd1, 5'd0,  1'b0, 32'h0,        1'b0, 1'b1};
        tv[11] = '{OP_LW,  32'h10,       32'h0,        5'd0, 5'd8,  1'b1, 32'h12345678, 1'b1, 1'b0};
        tv[12] = '{OP_LH,  32'h21,       32'h0,        5'd0, 5'd9,  1'b1, 32'h0,        1'b0, 1'b1};
        tv[13] = '{OP_NONE,32'hCAFEBABE, 32'h0,        5'd0, 5'd9,  1'b1, 32'hCAFEBABE, 1'b1, 1'b0};
        tv[14] = '{OP_SW,  32'h40,       32'h0,        5'd9, 5'd0,  1'b0, 32'h40,       1'b0, 1'b0};
        tv[15] = '{OP_LW,  32'h40,       32'h0,        5'd0, 5'd10, 1'b1, 32'hCAFEBABE, 1'b1, 1'b0};
        tv[16] = '{OP_NONE,32'h11111111, 32'h0,        5'd0, 5'd0,  1'b1, 32'h11111111, 1'b1, 1'b0};
        tv[17] = '{OP_SW,  32'h44,       32'h22222222, 5'd0, 5'd0,  1'b0, 32'h44,       1'b0, 1'b0};
        tv[18] = '{OP_LW,  32'h44,       32'h0,        5'd0, 5'd11, 1'b1, 32'h22222222, 1'b1, 1'b0};
        tv[19] = '{OP_SB,  32'h1047,     32'h000000A5, 5'd2, 5'd0,  1'b0, 32'h1047,     1'b0, 1'b0};
        tv[20] = '{OP_LBU, 32'h47,       32'h0,        5'd0, 5'd12, 1'b1, 32'h000000A5, 1'b1, 1'b0};
        tv[21] = '{OP_LW,  32'h1010,     32'h0,        5'd0, 5'd13, 1'b1, 32'h12345678, 1'b1, 1'b0};
        tv[22] = '{OP_LW,  32'h42,       32'h0,        5'd0, 5'd14, 1'b1, 32'h0,        1'b0, 1'b1};
        tv[23] = '{OP_NONE,32'h5,        32'h0,        5'd0, 5'd2,  1'b0, 32'h5,        1'b0, 1'b0};
        tv[24] = '{OP_SW,  32'h48,       32'h77,       5'd2, 5'd0,  1'b0, 32'h48,       1'b0, 1'b0};
        tv[25] = '{OP_LW,  32'h48,       32'h0,        5'd0, 5'd1,  1'b1, 32'h77,       1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready1", {31'd0, rdy1}, 1);  chk("rst_ready3", {31'd0, rdy3}, 1);
        chk("rst_valid1", {31'd0, val1}, 0);  chk("rst_valid3", {31'd0, val3}, 0);
        chk("rst_rfwr1",  {31'd0, rfwr1}, 0); chk("rst_rfwr3",  {31'd0, rfwr3}, 0);
        chk("rst_mis1",   {31'd0, mis1}, 0);  chk("rst_mis3",   {31'd0, mis3}, 0);
        chk("rst_a31",    {27'd0, a31}, 0);   chk("rst_a33",    {27'd0, a33}, 0);
        chk("rst_wd1",    wd1, 0);            chk("rst_wd3",    wd3, 0);
        chk("rst_pc1",    pc1, 0);            chk("rst_pc3",    pc3, 0);

        // MEM_LAT=1 table, one instruction per cycle with no bubbles.
        for (int i = 0; i < 26; i++) begin
            issue(tv[i].op, tv[i].alu, tv[i].rd2, tv[i].rt, tv[i].a3, tv[i].rfwr, 32'h100 + 32'(4 * i));
            chk("tv_ready", {31'd0, o_ready}, 1);
            @(posedge clk); #1;
            chk($sformatf("tv%0d_valid", i), {31'd0, o_valid}, 1);
            chk($sformatf("tv%0d_wd", i),    o_wd, tv[i].wd);
            chk($sformatf("tv%0d_rfwr", i),  {31'd0, o_rfwr}, {31'd0, tv[i].wrf});
            chk($sformatf("tv%0d_mis", i),   {31'd0, o_mis}, {31'd0, tv[i].mis});
            chk($sformatf("tv%0d_a3", i),    {27'd0, o_a3}, {27'd0, tv[i].a3});
            chk($sformatf("tv%0d_pc", i),    o_pc, 32'h100 + 32'(4 * i));
        end
        d_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", {31'd0, o_valid}, 0);
        chk("idle_rfwr",  {31'd0, o_rfwr}, 0);
        chk("idle_mis",   {31'd0, o_mis}, 0);
        chk("idle_a3",    {27'd0, o_a3}, 1);
        chk("idle_wd",    o_wd, 32'h77);
        chk("idle_pc",    o_pc, 32'h100 + 32'(4 * 25));

        // MEM_LAT=3 latency and back-pressure.
        sel = 1'b1;
        issue(OP_SW, 32'h08, 32'hA5A55A5A, 5'd0, 5'd0, 1'b0, 32'h300);
        accept_wait();
        wait_retire();
        chk("l3_sw_wd", o_wd, 32'h08);
        issue(OP_LW, 32'h08, 32'h0, 5'd0, 5'd3, 1'b1, 32'h200);
        @(posedge clk); #1;
        chk("l3_ready_t1", {31'd0, o_ready}, 0); chk("l3_valid_t1", {31'd0, o_valid}, 0);
        issue(OP_NONE, 32'h99, 32'h0, 5'd0, 5'd4, 1'b1, 32'h204);
        @(posedge clk); #1;
        chk("l3_ready_t2", {31'd0, o_ready}, 0); chk("l3_valid_t2", {31'd0, o_valid}, 0);
        @(posedge clk); #1;
        chk("l3_ready_t3", {31'd0, o_ready}, 1); chk("l3_valid_t3", {31'd0, o_valid}, 1);
        chk("l3_lw_wd", o_wd, 32'hA5A55A5A);     chk("l3_lw_pc", o_pc, 32'h200);
        chk("l3_lw_a3", {27'd0, o_a3}, 3);
        @(posedge clk); #1;
        d_valid = 1'b0;
        chk("l3_add_valid", {31'd0, o_valid}, 1); chk("l3_add_wd", o_wd, 32'h99);
        chk("l3_add_pc", o_pc, 32'h204);
        @(posedge clk); #1;
        chk("l3_after_valid", {31'd0, o_valid}, 0);

        // Reset while a store is in flight.
        issue(OP_SW, 32'h50, 32'h55AA55AA, 5'd0, 5'd0, 1'b0, 32'h400);
        @(posedge clk); #1;
        d_valid = 1'b0;
        chk("busy_ready", {31'd0, o_ready}, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstb_valid", {31'd0, o_valid}, 0); chk("rstb_ready", {31'd0, o_ready}, 1);
        chk("rstb_wd", o_wd, 0);                chk("rstb_pc", o_pc, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rstb_quiet", {31'd0, o_valid}, 0);
        end
        issue(OP_LW, 32'h50, 32'h0, 5'd0, 5'd5, 1'b1, 32'h404);
        accept_wait();
        wait_retire();
        chk("rstb_lw_wd", o_wd, 0); chk("rstb_lw_rfwr", {31'd0, o_rfwr}, 1);
        issue(OP_LW, 32'h08, 32'h0, 5'd0, 5'd6, 1'b1, 32'h408);
        accept_wait();
        wait_retire();
        chk("rstb_clr_wd", o_wd, 0);

        sel = 1'b0;
        run_random(1, 400);
        sel = 1'b1;
        run_random(3, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
